ps2_cmd_sched: RTL and testbench
================================

PS2_CMD_SCHED -- requirements
Module: ps2_cmd_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000000, max clk cycles allowed for each wait-for-response phase.
REQ-002 Parameter MAX_RETRY, default 3, number of resends allowed per byte after a 0xFE response.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 reqRst  input  1  level request: send keyboard reset command 0xFF.
REQ-006 reqLed  input  1  level request: send set-LED command 0xED plus an argument.
REQ-007 ledBits  input  3  {caps, num, scroll}; sampled when the LED request is granted.
REQ-008 reqRate  input  1  level request: send typematic command 0xF3 plus an argument.
REQ-009 rateByte  input  7  typematic argument; sampled when the rate request is granted.
REQ-010 txStart  output  1  one-cycle pulse to the PS/2 transmitter to send txData.
REQ-011 txData  output  8  byte to transmit; held stable from txStart until txDone.
REQ-012 txDone  input  1  one-cycle pulse when the transmitter finishes a byte.
REQ-013 rxReady  input  1  one-cycle pulse when a received byte is valid.
REQ-014 rxData  input  8  received byte from the keyboard.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.
REQ-016 grant  output  3  one-hot {rate, led, rst}; pulses one cycle when that command completes successfully.
REQ-017 err  output  1  sticky failure flag; cleared only by the next grant or by reset.

Function
REQ-018 States: IDLE, SEND1, WAIT1, SEND2, WAIT2, WAIT_BAT, DONE, FAIL.
REQ-019 IDLE, fixed request priority: reqRst > reqLed > reqRate.
  - Granted command is latched together with its argument (ledBits zero-extended to 8 bits, or {1'b0, rateByte}).
  - Retry counter and timeout counter are cleared.
  - FSM goes to SEND1.
REQ-020 SEND1:
  - txData = command byte, txStart pulses for exactly one cycle.
  - Next state WAIT1; txDone is awaited inside WAIT1.
REQ-021 WAIT1/WAIT2 response handling, on rxReady after txDone has been seen:
  - 0xFA: advance. For reset, go to WAIT_BAT. For LED/rate, WAIT1 goes to SEND2 and WAIT2 goes to DONE.
  - 0xFE: if retry < MAX_RETRY, increment retry and resend the same byte (SEND1 or SEND2). Otherwise go to FAIL.
  - Any other byte: ignore and keep waiting.
REQ-022 SEND2: txData = latched argument, txStart pulses for one cycle, next state WAIT2; the retry counter restarts at 0.
REQ-023 WAIT_BAT: 0xAA goes to DONE; 0xFC goes to FAIL; any other byte is ignored.
REQ-024 Timeout counter:
  - Counts every cycle in WAIT1, WAIT2 and WAIT_BAT.
  - Reaching TIMEOUT_CYC-1 without the required response goes to FAIL.
  - Clears on each state entry.
REQ-025 DONE: pulse the matching grant bit for one cycle, clear err, return to IDLE.
REQ-026 FAIL: set err, no grant pulse, return to IDLE the next cycle; the failed request is not retried unless it is still asserted.
REQ-027 Requests are not queued. A request deasserted before it is granted is lost. Requests arriving while busy wait for IDLE.
REQ-028 Simultaneous txDone and rxReady in the same cycle: txDone is processed first, so an ACK in that cycle is accepted.
REQ-029 rxReady while IDLE: ignored; no state change, no output change.
REQ-030 Minimum latency, request to grant for a two-byte command: 1 (IDLE) + 1 (SEND1) + response wait + 1 (SEND2) + response wait + 1 (DONE) cycles.
REQ-031 txStart is never asserted between a txStart and its txDone.

Reset
REQ-032 reset low asynchronously forces, in any state including mid-transfer:
  - state = IDLE
  - txStart = 0, txData = 0x00
  - busy = 0, grant = 3'b000, err = 0
  - all counters and latches cleared.
REQ-033 After reset releases, the first grant decision is made on the first rising clk edge.

Verification
REQ-034 reqLed=1, ledBits=3'b101; transmitter acks each byte with 0xFA -> txData sequence 0xED, 0x05; grant=3'b010 pulses once; err=0.
REQ-035 reqRst and reqRate raised in the same cycle -> 0xFF sent first; after responses 0xFA, 0xAA, grant=3'b001; then 0xF3 is sent.
REQ-036 reqRate, rateByte=7'h2B; first byte answered 0xFE twice, then 0xFA; second byte answered 0xFA -> 0xF3 transmitted 3 times, then 0x2B; grant=3'b100.
REQ-037 reqLed with every byte answered 0xFE, MAX_RETRY=3 -> 0xED transmitted 4 times; err=1; no grant; FSM returns to IDLE.
REQ-038 reqLed, TIMEOUT_CYC=100, no response after txDone -> FAIL at 100 cycles after entering WAIT1; err=1.
REQ-039 reset driven low during WAIT2 -> all outputs at reset values immediately, without waiting for a clk edge; a new reqLed after release restarts from SEND1 with 0xED.

Source files
------------

// File: rtl/ps2_cmd_sched.sv
// PS/2 keyboard command scheduler.
// Arbitrates reset / set-LED / typematic requests, sends the command byte and
// its optional argument through a byte transmitter, and interprets the
// keyboard replies (ACK 0xFA, RESEND 0xFE, BAT 0xAA / 0xFC) with bounded
// retries and a per-phase response timeout.
//
// Handshake semantics: txStart is a one-cycle strobe that launches txData;
// txData is held until the transmitter answers with a one-cycle txDone, and
// no new txStart is issued in between. rxReady is a one-cycle valid strobe
// for rxData with no back-pressure; bytes arriving while nothing is awaited
// are dropped. A reply only counts once the byte's txDone has been seen (a
// txDone in the same cycle as rxReady counts as seen).
module ps2_cmd_sched #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reqRst,
    input  logic       reqLed,
    input  logic [2:0] ledBits,
    input  logic       reqRate,
    input  logic [6:0] rateByte,
    output logic       txStart,
    output logic [7:0] txData,
    input  logic       txDone,
    input  logic       rxReady,
    input  logic [7:0] rxData,
    output logic       busy,
    output logic [2:0] grant,
    output logic       err,
    output logic [2:0] dbgState
);

    typedef enum logic [2:0] {
        IDLE, SEND1, WAIT1, SEND2, WAIT2, WAIT_BAT, DONE, FAIL
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    localparam logic [7:0] KB_ACK    = 8'hFA;
    localparam logic [7:0] KB_RESEND = 8'hFE;
    localparam logic [7:0] KB_BAT_OK = 8'hAA;
    localparam logic [7:0] KB_BAT_NG = 8'hFC;

    state_t          state, next;
    logic [2:0]      cmd;        // one-hot {rate, led, rst} of the command in flight
    logic [7:0]      arg;        // argument byte latched at grant
    logic [RW-1:0]   retry;
    logic [TW-1:0]   tcnt;
    logic            txd_seen;   // txDone already observed in this wait phase
    logic            resp;       // a reply that is allowed to count
    logic            timed_out;
    logic            in_wait;
    logic            retry_ok;
    logic [2:0]      win_cmd;
    logic [7:0]      win_byte;
    logic [7:0]      win_arg;

    assign resp      = rxReady && (txd_seen || txDone);
    assign timed_out = (tcnt == T_LAST);
    assign in_wait   = (state == WAIT1) || (state == WAIT2) || (state == WAIT_BAT);
    assign retry_ok  = (retry < R_MAX);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    // Next-state decode, request arbitration and FSM-driven outputs.
    always_comb begin
        next     = state;
        txStart  = 1'b0;
        busy     = (state != IDLE);
        grant    = 3'b000;
        dbgState = state;
        win_cmd  = 3'b100;
        win_byte = 8'hF3;
        win_arg  = {1'b0, rateByte};
        if (reqRst) begin
            win_cmd  = 3'b001;
            win_byte = 8'hFF;
            win_arg  = 8'h00;
        end else if (reqLed) begin
            win_cmd  = 3'b010;
            win_byte = 8'hED;
            win_arg  = {5'b00000, ledBits};
        end
        case (state)
            IDLE:     if (reqRst || reqLed || reqRate) next = SEND1;
            SEND1: begin
                txStart = 1'b1;
                next    = WAIT1;
            end
            WAIT1: begin
                if (resp && rxData == KB_ACK)         next = cmd[0] ? WAIT_BAT : SEND2;
                else if (resp && rxData == KB_RESEND) next = retry_ok ? SEND1 : FAIL;
                else if (timed_out)                   next = FAIL;
            end
            SEND2: begin
                txStart = 1'b1;
                next    = WAIT2;
            end
            WAIT2: begin
                if (resp && rxData == KB_ACK)         next = DONE;
                else if (resp && rxData == KB_RESEND) next = retry_ok ? SEND2 : FAIL;
                else if (timed_out)                   next = FAIL;
            end
            WAIT_BAT: begin
                if (rxReady && rxData == KB_BAT_OK)      next = DONE;
                else if (rxReady && rxData == KB_BAT_NG) next = FAIL;
                else if (timed_out)                      next = FAIL;
            end
            DONE: begin
                grant = cmd;
                next  = IDLE;
            end
            FAIL:     next = IDLE;
            default:  next = IDLE;
        endcase
    end

    // Command latches, retry/timeout counters and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd      <= 3'b000;
            arg      <= 8'h00;
            txData   <= 8'h00;
            retry    <= '0;
            tcnt     <= '0;
            txd_seen <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (next != state) begin
                tcnt     <= '0;
                txd_seen <= 1'b0;
            end else begin
                if (in_wait) tcnt <= tcnt + 1'b1;
                if (txDone)  txd_seen <= 1'b1;
            end
            if (state == IDLE && next == SEND1) begin
                cmd    <= win_cmd;
                arg    <= win_arg;
                txData <= win_byte;
                retry  <= '0;
            end else if (state == WAIT1 && next == SEND2) begin
                txData <= arg;
                retry  <= '0;
            end else if ((state == WAIT1 && next == SEND1) ||
                         (state == WAIT2 && next == SEND2)) begin
                // txData still holds the byte being resent.
                retry <= retry + 1'b1;
            end
            if (next == FAIL)      err <= 1'b1;
            else if (next == DONE) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Bench for ps2_cmd_sched: emulates the byte transmitter and the keyboard,
// predicts transmitted bytes and outcome from the command/retry rules.
module tb_ps2_cmd_sched;

  localparam int TO = 100;
  localparam int MR = 3;
  localparam logic [8:0] NONE = 9'h100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reqRst, reqLed, reqRate;
  logic [2:0] ledBits;
  logic [6:0] rateByte;
  logic       txStart, txDone, busy, err;
  logic [7:0] txData;
  logic       rxReady;
  logic [7:0] rxData;
  logic [2:0] grant, dbgState;

  logic       rsp_done, rsp_rx, idle_rx;
  logic [7:0] rsp_data, idle_data;
  assign txDone  = rsp_done;
  assign rxReady = rsp_rx | idle_rx;
  assign rxData  = idle_rx ? idle_data : rsp_data;

  ps2_cmd_sched #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .reqRst(reqRst), .reqLed(reqLed), .ledBits(ledBits),
    .reqRate(reqRate), .rateByte(rateByte), .txStart(txStart), .txData(txData),
    .txDone(txDone), .rxReady(rxReady), .rxData(rxData), .busy(busy),
    .grant(grant), .err(err), .dbgState(dbgState)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [8:0] resp_q[$], bat_q[$], plan_q[$], bplan_q[$];
  int n_chk = 0, n_err = 0;
  bit fast = 0;
  bit prev_err = 0;
  int unsigned last_start = 0, req_cyc = 0, gcyc = 0;
  int gcnt = 0;
  logic [2:0] glast = 3'b000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // grant monitor
  initial forever begin
    @(negedge clk);
    if (grant !== 3'b000) begin
      gcnt++;
      glast = grant;
      gcyc = cyc;
    end
  end

  // ---------------- transmitter / keyboard driver ----------------
  task automatic send_rsp(input logic [7:0] v);
    int j;
    logic [7:0] jb;
    j = fast ? 0 : int'($urandom_range(0, 2));
    for (int k = 0; k <= j; k++) begin
      @(negedge clk);
      rsp_done = 1'b0;
      rsp_rx   = 1'b0;
      if (!fast && $urandom_range(0, 1) == 1) @(negedge clk);
      do jb = 8'($urandom_range(0, 255));
      while (jb == 8'hFA || jb == 8'hFE || jb == 8'hAA || jb == 8'hFC);
      rsp_rx   = 1'b1;
      rsp_data = (k == j) ? v : jb;
    end
  endtask

  task automatic handle_byte();
    logic [7:0] b;
    logic [8:0] r, bt;
    int d;
    bit sim, stray;
    b = txData;
    last_start = cyc;
    if (exp_q.size() == 0) chk("tx_unexpected", 32'(txData), 32'(NONE));
    else chk("tx_byte", 32'(txData), 32'(exp_q.pop_front()));
    r = (resp_q.size() != 0) ? resp_q.pop_front() : NONE;
    d     = fast ? 0 : int'($urandom_range(0, 3));
    sim   = fast || ($urandom_range(0, 3) == 0);
    stray = !fast && ($urandom_range(0, 2) == 0);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      rsp_rx = 1'b0;
      chk("tx_hold", 32'({txStart, txData}), 32'({1'b0, b}));
      if (stray && i == 0) begin
        rsp_rx   = 1'b1;
        rsp_data = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    rsp_rx = 1'b0;
    chk("tx_hold", 32'({txStart, txData}), 32'({1'b0, b}));
    rsp_done = 1'b1;
    if (r != NONE) begin
      if (sim) begin
        rsp_rx   = 1'b1;
        rsp_data = r[7:0];
      end else begin
        send_rsp(r[7:0]);
      end
      if (r == 9'h0FA && b == 8'hFF) begin
        bt = (bat_q.size() != 0) ? bat_q.pop_front() : NONE;
        if (bt != NONE) send_rsp(bt[7:0]);
      end
    end
  endtask

  initial begin
    rsp_done = 1'b0;
    rsp_rx   = 1'b0;
    rsp_data = 8'h00;
    forever begin
      @(negedge clk);
      rsp_done = 1'b0;
      rsp_rx   = 1'b0;
      if (txStart === 1'b1) handle_byte();
    end
  end

  // ---------------- reference model ----------------
  task automatic next_resp(output logic [8:0] r);
    int x;
    if (plan_q.size() != 0) r = plan_q.pop_front();
    else begin
      x = int'($urandom_range(0, 99));
      r = (x < 70) ? 9'h0FA : (x < 96) ? 9'h0FE : NONE;
    end
  endtask

  task automatic next_bat(output logic [8:0] r);
    int x;
    if (bplan_q.size() != 0) r = bplan_q.pop_front();
    else begin
      x = int'($urandom_range(0, 99));
      r = (x < 88) ? 9'h0AA : (x < 96) ? 9'h0FC : NONE;
    end
  endtask

  // One request episode: model predicts bytes/outcome, then drive and check.
  task automatic run_txn(input logic [2:0] reqs, input logic [2:0] keep,
                         input logic [2:0] led, input logic [6:0] rate,
                         input int exp_lat, input int exp_idle);
    logic [7:0] bytes[$];
    logic [2:0] win;
    logic [8:0] r;
    bit ok, exp_e;
    int n;
    int unsigned idle_cyc;
    ok = 1;
    if (reqs[0]) begin
      win = 3'b001; bytes.push_back(8'hFF);
    end else if (reqs[1]) begin
      win = 3'b010; bytes.push_back(8'hED); bytes.push_back({5'b0, led});
    end else begin
      win = 3'b100; bytes.push_back(8'hF3); bytes.push_back({1'b0, rate});
    end
    for (int i = 0; i < bytes.size() && ok; i++) begin
      int fes;
      bit go;
      fes = 0;
      go  = 1;
      while (go) begin
        exp_q.push_back(bytes[i]);
        next_resp(r);
        resp_q.push_back(r);
        if (r == 9'h0FA) go = 0;
        else if (r == 9'h0FE && fes < MR) fes++;
        else begin
          ok = 0;
          go = 0;
        end
      end
    end
    if (ok && win == 3'b001) begin
      next_bat(r);
      bat_q.push_back(r);
      if (r != 9'h0AA) ok = 0;
    end
    exp_e = !ok;
    plan_q.delete();
    bplan_q.delete();

    @(negedge clk);
    reqRst = reqs[0]; reqLed = reqs[1]; reqRate = reqs[2];
    ledBits = led; rateByte = rate;
    gcnt = 0; glast = 3'b000; req_cyc = cyc;
    n = 0;
    while (!busy && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("start", 32'(busy), 32'd1);
    if (busy) chk("err_sticky", 32'(err), 32'(prev_err));
    reqRst = reqRst & keep[0]; reqLed = reqLed & keep[1]; reqRate = reqRate & keep[2];
    if (keep == 3'b000) begin
      ledBits  = 3'($urandom_range(0, 7));
      rateByte = 7'($urandom_range(0, 127));
    end
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    idle_cyc = cyc;
    chk("finish", 32'(busy), 32'd0);
    if (busy) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete(); resp_q.delete(); bat_q.delete();
    end
    chk("grant", 32'(glast), 32'(ok ? win : 3'b000));
    chk("grant_pulses", 32'(gcnt), ok ? 32'd1 : 32'd0);
    chk("err", 32'(err), 32'(exp_e));
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    chk("resp_left", 32'(resp_q.size() + bat_q.size()), 32'd0);
    if (exp_lat != 0) chk("latency", 32'(gcyc - req_cyc), 32'(exp_lat));
    if (exp_idle != 0) chk("timeout_at", 32'(idle_cyc - last_start), 32'(exp_idle));
    prev_err = exp_e;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b0; reqRst = 0; reqLed = 0; reqRate = 0;
    ledBits = 0; rateByte = 0; idle_rx = 0; idle_data = 0;
    #23;
    chk("rst_txStart", 32'(txStart), 32'd0);
    chk("rst_txData", 32'(txData), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // replies while idle are ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_rx = 1'b1;
      idle_data = (i == 0) ? 8'hFA : (i == 1) ? 8'hFE : 8'hAA;
      @(negedge clk);
      idle_rx = 1'b0;
      chk("idle_rx_busy", 32'({busy, txStart, grant, err}), 32'd0);
    end

    // LED 101, all ACK
    plan_q = {9'h0FA, 9'h0FA};
    run_txn(3'b010, 3'b000, 3'b101, 7'h00, 0, 0);
    // rate 2B: two resends then ACK, then ACK
    plan_q = {9'h0FE, 9'h0FE, 9'h0FA, 9'h0FA};
    run_txn(3'b100, 3'b000, 3'b000, 7'h2B, 0, 0);
    // LED with every byte resent: retries exhausted
    plan_q = {9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE};
    run_txn(3'b010, 3'b000, 3'b110, 7'h00, 0, 0);
    // LED, silence after txDone: timeout 100 cycles after WAIT1 entry
    plan_q = {NONE};
    run_txn(3'b010, 3'b000, 3'b001, 7'h00, 0, 102);
    // reset and rate together: reset first, rate left asserted
    plan_q = {9'h0FA}; bplan_q = {9'h0AA};
    run_txn(3'b101, 3'b100, 3'b000, 7'h11, 0, 0);
    plan_q = {9'h0FA, 9'h0FA};
    run_txn(3'b100, 3'b000, 3'b000, 7'h11, 0, 0);
    // minimum two-byte latency
    fast = 1;
    plan_q = {9'h0FA, 9'h0FA};
    run_txn(3'b010, 3'b000, 3'b010, 7'h00, 5, 0);
    fast = 0;

    // asynchronous reset during WAIT2
    exp_q = {8'hED, 8'h05};
    resp_q = {9'h0FA, NONE};
    @(negedge clk);
    reqLed = 1'b1; ledBits = 3'b101;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reqLed = 1'b0;
    chk("wait2_reached", 32'(exp_q.size()), 32'd0);
    repeat (8) @(negedge clk);
    chk("wait2_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_txStart", 32'(txStart), 32'd0);
    chk("async_txData", 32'(txData), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); resp_q.delete(); bat_q.delete();
    prev_err = 0;
    plan_q = {9'h0FA, 9'h0FA};
    run_txn(3'b010, 3'b000, 3'b011, 7'h00, 0, 0);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      run_txn(3'($urandom_range(1, 7)), 3'b000, 3'($urandom_range(0, 7)),
              7'($urandom_range(0, 127)), 0, 0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
